iot_filter_param: RTL and testbench

IOT_FILTER_PARAM -- requirements
Module: iot_filter_param

---
 rtl/iot_filter_pkg.sv | 20 ++
 rtl/iot_word_shifter.sv | 53 +++++
 rtl/iot_filter_param.sv | 212 +++++++++++++++++++++
 tb/tb_iot_filter_param.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iot_filter_pkg.sv
// Shared constants for the IoT byte-stream filter: function encodings,
// FSM state codes and the byte width.
package iot_filter_pkg;

   localparam int BYTE_W = 8;

   localparam logic [2:0] FN_PASS = 3'd0;
   localparam logic [2:0] FN_MAX  = 3'd1;
   localparam logic [2:0] FN_MIN  = 3'd2;
   localparam logic [2:0] FN_AVG  = 3'd3;
   localparam logic [2:0] FN_EXT  = 3'd4;
   localparam logic [2:0] FN_EXC  = 3'd5;
   localparam logic [2:0] FN_PMAX = 3'd6;
   localparam logic [2:0] FN_PMIN = 3'd7;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

endpackage

// File: rtl/iot_word_shifter.sv
// Byte-to-word assembler: shifts accepted bytes in MSB-first and flags the
// byte that completes a word, presenting the completed word combinationally.
module iot_word_shifter
   import iot_filter_pkg::*;
#(
   parameter int WORD_BYTES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           byte_en,
   input  logic [BYTE_W-1:0]              byte_in,
   output logic                           byte_first,
   output logic                           word_done,
   output logic [BYTE_W*WORD_BYTES-1:0]   word_next
);

   localparam int WORD_W = BYTE_W * WORD_BYTES;
   localparam int BC_W   = $clog2(WORD_BYTES);

   logic [BC_W-1:0]   cnt_q, cnt_d;
   logic [WORD_W-1:0] word_q, word_d;

   // Next-state for the shift register and byte counter
   always_comb begin
      word_next  = {word_q[WORD_W-BYTE_W-1:0], byte_in};
      byte_first = (cnt_q == {BC_W{1'b0}});
      word_done  = byte_en && (cnt_q == BC_W'(WORD_BYTES - 1));
      cnt_d      = cnt_q;
      word_d     = word_q;
      if (byte_en) begin
         word_d = word_next;
         if (word_done) begin
            cnt_d = {BC_W{1'b0}};
         end else begin
            cnt_d = cnt_q + BC_W'(1);
         end
      end else begin
         word_d = word_q;
      end
   end

   // Shift register and byte counter flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= {BC_W{1'b0}};
         word_q <= {WORD_W{1'b0}};
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/iot_filter_param.sv
// IoT stream filter: assembles bytes into words and applies a per-round
// word function (PASS/EXT/EXC), round function (MAX/MIN/AVG) or peak tracker.
module iot_filter_param
   import iot_filter_pkg::*;
#(
   parameter int WORD_BYTES  = 16,
   parameter int ROUND_WORDS = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_en,
   input  logic [7:0]                   iot_in,
   input  logic [2:0]                   fn_sel,
   input  logic [8*WORD_BYTES-1:0]      lo_th,
   input  logic [8*WORD_BYTES-1:0]      hi_th,
   output logic                         busy,
   output logic                         valid,
   output logic [8*WORD_BYTES-1:0]      iot_out
);

   localparam int WORD_W = 8 * WORD_BYTES;
   localparam int WC_W   = $clog2(ROUND_WORDS);
   localparam int ACC_W  = WORD_W + WC_W;

   logic [1:0]        state_q, state_d;
   logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
   logic [2:0]        fn_q, fn_d;
   logic [WORD_W-1:0] lo_q, lo_d, hi_q, hi_d;
   logic              first_q, first_d;
   logic [WORD_W-1:0] ext_q, ext_d, peak_q, peak_d, out_q, out_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              valid_q, valid_d;

   logic              accept, round_start, first_word, last_word;
   logic              byte_first, word_done;
   logic [WORD_W-1:0] word_next, run_max, run_min;
   logic [ACC_W-1:0]  acc_sum;

   iot_word_shifter #(.WORD_BYTES(WORD_BYTES)) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .byte_en    (accept),
      .byte_in    (iot_in),
      .byte_first (byte_first),
      .word_done  (word_done),
      .word_next  (word_next)
   );

   assign busy    = (state_q == S_OUT);
   assign valid   = valid_q;
   assign iot_out = out_q;

   // Round control, function latch and per-word / per-round result selection
   always_comb begin
      accept      = in_en && (state_q != S_OUT);
      first_word  = (word_cnt_q == {WC_W{1'b0}});
      last_word   = (word_cnt_q == WC_W'(ROUND_WORDS - 1));
      round_start = accept && byte_first && first_word;
      run_max     = (first_word || (word_next > ext_q)) ? word_next : ext_q;
      run_min     = (first_word || (word_next < ext_q)) ? word_next : ext_q;
      acc_sum     = (first_word ? {ACC_W{1'b0}} : acc_q) + ACC_W'(word_next);

      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      fn_d       = fn_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      first_d    = first_q;
      ext_d      = ext_q;
      peak_d     = peak_q;
      acc_d      = acc_q;
      out_d      = out_q;
      valid_d    = 1'b0;

      // A new function restarts peak tracking from a clean first round
      if (round_start) begin
         fn_d = fn_sel;
         lo_d = lo_th;
         hi_d = hi_th;
         if (fn_sel != fn_q) begin
            first_d = 1'b1;
            peak_d  = {WORD_W{1'b0}};
         end else begin
            first_d = first_q;
         end
      end else begin
         fn_d = fn_q;
      end

      case (state_q)
         S_IDLE:  state_d = accept ? S_RUN : S_IDLE;
         S_RUN:   state_d = (word_done && last_word) ? S_OUT : S_RUN;
         S_OUT:   state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase

      if (word_done) begin
         word_cnt_d = last_word ? {WC_W{1'b0}} : word_cnt_q + WC_W'(1);
         case (fn_q)
            FN_PASS: begin
               out_d   = word_next;
               valid_d = 1'b1;
            end
            FN_EXT: begin
               if ((word_next > lo_q) && (word_next < hi_q)) begin
                  out_d   = word_next;
                  valid_d = 1'b1;
               end else begin
                  valid_d = 1'b0;
               end
            end
            FN_EXC: begin
               if ((word_next < lo_q) || (word_next > hi_q)) begin
                  out_d   = word_next;
                  valid_d = 1'b1;
               end else begin
                  valid_d = 1'b0;
               end
            end
            FN_MAX:  ext_d = run_max;
            FN_MIN:  ext_d = run_min;
            FN_AVG:  acc_d = acc_sum;
            FN_PMAX: begin
               if (first_q) begin
                  ext_d = run_max;
               end else if (word_next > peak_q) begin
                  out_d   = word_next;
                  valid_d = 1'b1;
                  peak_d  = word_next;
               end else begin
                  valid_d = 1'b0;
               end
            end
            FN_PMIN: begin
               if (first_q) begin
                  ext_d = run_min;
               end else if (word_next < peak_q) begin
                  out_d   = word_next;
                  valid_d = 1'b1;
                  peak_d  = word_next;
               end else begin
                  valid_d = 1'b0;
               end
            end
            default: valid_d = 1'b0;
         endcase

         // Round results are registered here so they appear during S_OUT
         if (last_word) begin
            first_d = 1'b0;
            case (fn_q)
               FN_MAX: begin
                  out_d   = run_max;
                  valid_d = 1'b1;
               end
               FN_MIN: begin
                  out_d   = run_min;
                  valid_d = 1'b1;
               end
               FN_AVG: begin
                  out_d   = WORD_W'(acc_sum >> WC_W);
                  valid_d = 1'b1;
               end
               FN_PMAX, FN_PMIN: begin
                  if (first_q) begin
                     out_d   = (fn_q == FN_PMAX) ? run_max : run_min;
                     peak_d  = (fn_q == FN_PMAX) ? run_max : run_min;
                     valid_d = 1'b1;
                  end else begin
                     peak_d = peak_d;
                  end
               end
               default: first_d = 1'b0;
            endcase
         end else begin
            first_d = first_d;
         end
      end else begin
         word_cnt_d = word_cnt_q;
      end
   end

   // Filter state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         word_cnt_q <= {WC_W{1'b0}};
         fn_q       <= FN_PASS;
         lo_q       <= {WORD_W{1'b0}};
         hi_q       <= {WORD_W{1'b0}};
         first_q    <= 1'b1;
         ext_q      <= {WORD_W{1'b0}};
         peak_q     <= {WORD_W{1'b0}};
         acc_q      <= {ACC_W{1'b0}};
         out_q      <= {WORD_W{1'b0}};
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         fn_q       <= fn_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         first_q    <= first_d;
         ext_q      <= ext_d;
         peak_q     <= peak_d;
         acc_q      <= acc_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
      end
   end

endmodule

// File: tb/tb_iot_filter_param.sv
// Directed self-checking bench for iot_filter_param with default parameters
// (16-byte words, 8 words per round).
module tb_iot_filter_param;

   logic         clk;
   logic         rst;
   logic         in_en;
   logic [7:0]   iot_in;
   logic [2:0]   fn_sel;
   logic [127:0] lo_th;
   logic [127:0] hi_th;
   logic         busy;
   logic         valid;
   logic [127:0] iot_out;

   int           nchk;
   int           nfail;
   int           cyc;
   int           last_acc;
   logic [127:0] out_q [$];
   logic         busy_q [$];
   int           cyc_q [$];

   iot_filter_param #(.WORD_BYTES(16), .ROUND_WORDS(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_en   (in_en),
      .iot_in  (iot_in),
      .fn_sel  (fn_sel),
      .lo_th   (lo_th),
      .hi_th   (hi_th),
      .busy    (busy),
      .valid   (valid),
      .iot_out (iot_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter: value after an edge names that edge
   always @(posedge clk) cyc <= cyc + 1;

   // Record every valid pulse away from the active edge
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         out_q.push_back(iot_out);
         busy_q.push_back(busy);
         cyc_q.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] rep(input logic [7:0] b);
      return {16{b}};
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit done;
      int tries;
      done   = 1'b0;
      tries  = 0;
      in_en  = 1'b1;
      iot_in = b;
      while (!done && tries < 32) begin
         @(negedge clk);
         done = (busy === 1'b0);
         @(posedge clk);
         #1;
         tries++;
      end
      in_en = 1'b0;
      if (!done) begin
         nchk++;
         nfail++;
         $display("FAIL send_byte_timeout: busy stayed %b, required 0", busy);
      end else begin
         last_acc = cyc;
      end
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [127:0] w, input int gap);
      for (int i = 0; i < 16; i++) send_byte(w[127-8*i -: 8], gap);
   endtask

   task automatic clear_rec();
      repeat (3) @(posedge clk);
      #1;
      out_q.delete();
      busy_q.delete();
      cyc_q.delete();
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_en = 1'b0; iot_in = 8'h00; fn_sel = 3'd0;
      lo_th = 128'h0; hi_th = 128'h0;
      repeat (3) @(posedge clk);
      #1;
      nchk++; if (valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b required 0", valid); end
      nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b required 0", busy); end
      nchk++; if (iot_out !== 128'h0) begin nfail++; $display("FAIL reset_out: got %h required 0", iot_out); end
      #2 rst = 1'b0;
   endtask

   task automatic test_max(input int gap, input string tag);
      fn_sel = 3'd1;
      clear_rec();
      for (int k = 0; k < 8; k++) begin
         send_word(rep(8'(8'h10 + k)), gap);
         fn_sel = 3'd0;
      end
      settle();
      nchk++;
      if (out_q.size() !== 1) begin nfail++; $display("FAIL %s_count: got %0d required 1", tag, out_q.size()); end
      else begin
         nchk++; if (out_q[0] !== rep(8'h17)) begin nfail++; $display("FAIL %s_value: got %h required %h", tag, out_q[0], rep(8'h17)); end
         nchk++; if (busy_q[0] !== 1'b1) begin nfail++; $display("FAIL %s_busy: got %b required 1", tag, busy_q[0]); end
         nchk++; if (cyc_q[0] !== last_acc) begin nfail++; $display("FAIL %s_latency: got cycle %0d required %0d", tag, cyc_q[0], last_acc); end
      end
   endtask

   task automatic test_min();
      logic [7:0] v [8];
      v = '{8'h33, 8'h21, 8'h45, 8'h21, 8'h90, 8'h22, 8'h50, 8'h60};
      fn_sel = 3'd2;
      clear_rec();
      for (int k = 0; k < 8; k++) send_word(rep(v[k]), 0);
      settle();
      nchk++;
      if (out_q.size() !== 1) begin nfail++; $display("FAIL min_count: got %0d required 1", out_q.size()); end
      else begin
         nchk++; if (out_q[0] !== rep(8'h21)) begin nfail++; $display("FAIL min_value: got %h required %h", out_q[0], rep(8'h21)); end
      end
   endtask

   task automatic test_avg();
      logic [7:0] v [8];
      v = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h08, 8'h06};
      fn_sel = 3'd3;
      clear_rec();
      for (int k = 0; k < 8; k++) send_word({120'h0, v[k]}, 0);
      for (int k = 0; k < 8; k++) send_word({128{1'b1}}, 0);
      settle();
      nchk++;
      if (out_q.size() !== 2) begin nfail++; $display("FAIL avg_count: got %0d required 2", out_q.size()); end
      else begin
         nchk++; if (out_q[0] !== 128'h0D) begin nfail++; $display("FAIL avg_value: got %h required %h", out_q[0], 128'h0D); end
         nchk++; if (out_q[1] !== {128{1'b1}}) begin nfail++; $display("FAIL avg_wide_sum: got %h required all ones", out_q[1]); end
      end
   endtask

   task automatic test_pass();
      logic [127:0] w [8];
      int           acc [8];
      fn_sel = 3'd0;
      clear_rec();
      for (int k = 0; k < 8; k++) begin
         w[k] = {4{32'hA5C30000 + 32'(k * 7)}};
         send_word(w[k], 0);
         acc[k] = last_acc;
      end
      settle();
      nchk++;
      if (out_q.size() !== 8) begin nfail++; $display("FAIL pass_count: got %0d required 8", out_q.size()); end
      else begin
         for (int k = 0; k < 8; k++) begin
            nchk++; if (out_q[k] !== w[k]) begin nfail++; $display("FAIL pass_value%0d: got %h required %h", k, out_q[k], w[k]); end
            nchk++; if (cyc_q[k] !== acc[k]) begin nfail++; $display("FAIL pass_latency%0d: got cycle %0d required %0d", k, cyc_q[k], acc[k]); end
         end
      end
   endtask

   task automatic test_ext_exc();
      logic [127:0] lo, hi;
      int           acc0;
      lo = {8'h6F, {15{8'hFF}}};
      hi = {8'hAF, {15{8'hFF}}};
      fn_sel = 3'd4; lo_th = lo; hi_th = hi;
      clear_rec();
      send_word(rep(8'h70), 0); acc0 = last_acc;
      lo_th = 128'h0; hi_th = {128{1'b1}};
      send_word(rep(8'hB0), 0);
      send_word(rep(8'h60), 0);
      send_word(lo, 0);
      send_word(hi, 0);
      for (int k = 0; k < 3; k++) send_word(rep(8'h60), 0);
      settle();
      nchk++;
      if (out_q.size() !== 1) begin nfail++; $display("FAIL ext_count: got %0d required 1", out_q.size()); end
      else begin
         nchk++; if (out_q[0] !== rep(8'h70)) begin nfail++; $display("FAIL ext_value: got %h required %h", out_q[0], rep(8'h70)); end
         nchk++; if (cyc_q[0] !== acc0) begin nfail++; $display("FAIL ext_latency: got cycle %0d required %0d", cyc_q[0], acc0); end
      end
      fn_sel = 3'd5; lo_th = lo; hi_th = hi;
      clear_rec();
      send_word(rep(8'h70), 0);
      send_word(rep(8'hB0), 0);
      send_word(rep(8'h60), 0);
      send_word(lo, 0);
      send_word(hi, 0);
      for (int k = 0; k < 3; k++) send_word(rep(8'h70), 0);
      settle();
      nchk++;
      if (out_q.size() !== 2) begin nfail++; $display("FAIL exc_count: got %0d required 2", out_q.size()); end
      else begin
         nchk++; if (out_q[0] !== rep(8'hB0)) begin nfail++; $display("FAIL exc_value0: got %h required %h", out_q[0], rep(8'hB0)); end
         nchk++; if (out_q[1] !== rep(8'h60)) begin nfail++; $display("FAIL exc_value1: got %h required %h", out_q[1], rep(8'h60)); end
      end
   endtask

   task automatic peak_round(input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] fill,
                             input int exp_n, input logic [7:0] exp_v, input logic exp_busy,
                             input string tag);
      fn_sel = fn;
      clear_rec();
      send_word(rep(a), 0);
      send_word(rep(b), 0);
      send_word(rep(c), 0);
      for (int k = 0; k < 5; k++) send_word(rep(fill), 0);
      settle();
      nchk++;
      if (out_q.size() !== exp_n) begin nfail++; $display("FAIL %s_count: got %0d required %0d", tag, out_q.size(), exp_n); end
      else if (exp_n > 0) begin
         nchk++; if (out_q[0] !== rep(exp_v)) begin nfail++; $display("FAIL %s_value: got %h required %h", tag, out_q[0], rep(exp_v)); end
         nchk++; if (busy_q[0] !== exp_busy) begin nfail++; $display("FAIL %s_busy: got %b required %b", tag, busy_q[0], exp_busy); end
      end
   endtask

   task automatic test_peak();
      peak_round(3'd6, 8'h10, 8'h50, 8'h20, 8'h30, 1, 8'h50, 1'b1, "pmax_r1");
      peak_round(3'd6, 8'h40, 8'h60, 8'h55, 8'h40, 1, 8'h60, 1'b0, "pmax_r2");
      peak_round(3'd6, 8'h60, 8'h61, 8'h5F, 8'h61, 1, 8'h61, 1'b0, "pmax_r3");
      peak_round(3'd7, 8'h30, 8'h20, 8'h25, 8'h28, 1, 8'h20, 1'b1, "pmin_r1");
      peak_round(3'd7, 8'h20, 8'h1F, 8'h21, 8'h30, 1, 8'h1F, 1'b0, "pmin_r2");
   endtask

   task automatic test_back_to_back();
      fn_sel = 3'd1;
      clear_rec();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 8; k++) send_word(rep(8'(8'h10 + k)), 0);
      settle();
      nchk++;
      if (out_q.size() !== 2) begin nfail++; $display("FAIL b2b_count: got %0d required 2", out_q.size()); end
      else begin
         nchk++; if (out_q[0] !== rep(8'h17)) begin nfail++; $display("FAIL b2b_value0: got %h required %h", out_q[0], rep(8'h17)); end
         nchk++; if (out_q[1] !== rep(8'h17)) begin nfail++; $display("FAIL b2b_value1: got %h required %h", out_q[1], rep(8'h17)); end
      end
   endtask

   task automatic test_rst_mid();
      logic [7:0] v [8];
      v = '{8'h40, 8'h20, 8'h35, 8'h90, 8'h21, 8'h77, 8'h30, 8'h66};
      fn_sel = 3'd2;
      clear_rec();
      for (int k = 0; k < 4; k++) send_word(rep(8'h01), 0);
      for (int k = 0; k < 6; k++) send_byte(8'h00, 0);
      rst = 1'b1;
      #2;
      nchk++; if (valid !== 1'b0) begin nfail++; $display("FAIL rstmid_valid: got %b required 0", valid); end
      nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL rstmid_busy: got %b required 0", busy); end
      nchk++; if (iot_out !== 128'h0) begin nfail++; $display("FAIL rstmid_out: got %h required 0", iot_out); end
      @(posedge clk);
      #2 rst = 1'b0;
      clear_rec();
      for (int k = 0; k < 8; k++) send_word(rep(v[k]), 0);
      settle();
      nchk++;
      if (out_q.size() !== 1) begin nfail++; $display("FAIL rstmid_count: got %0d required 1", out_q.size()); end
      else begin
         nchk++; if (out_q[0] !== rep(8'h20)) begin nfail++; $display("FAIL rstmid_min: got %h required %h", out_q[0], rep(8'h20)); end
      end
   endtask

   initial begin
      nchk = 0;
      nfail = 0;
      cyc = 0;
      last_acc = 0;
      test_reset();
      test_max(0, "max");
      test_min();
      test_avg();
      test_pass();
      test_ext_exc();
      test_peak();
      test_max(2, "gaps");
      test_back_to_back();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
